// File: rtl/lmdpl_nand_vec.sv
// ----------------------------------------------------------------------------
// lmdpl_nand_vec
//
// WIDTH-bit masked dual-rail precharge NAND stage. Each bit-slice computes
// out_m = ~(in0 & in1) ^ m_out. The unmasked operands are never formed.
//
// Per operation the block does the following:
//   - accepts a masked operand word with its masks over a valid/ready handshake;
//   - runs one precharge cycle, in which it:
//       * forces out_m to zero,
//       * samples a fresh output mask from rnd,
//       * builds a per-bit 4-entry lookup table from the masks;
//   - evaluates for EVAL_CYCLES cycles by indexing that table with the masked
//     operand bits only;
//   - presents the result over a valid/ready handshake;
//   - wipes the captured operands and the table when the result is taken.
//
// Parameters:
//   WIDTH        number of independent masked NAND bit-slices (>= 1)
//   EVAL_CYCLES  evaluate-phase length in clock cycles (>= 1)
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand word valid
//   in_ready   block idle and able to accept an operand word
//   in0_m      masked operand 0 (in0 ^ m_in0)
//   in1_m      masked operand 1 (in1 ^ m_in1)
//   m_in0      mask of operand 0
//   m_in1      mask of operand 1
//   rnd        fresh PRNG bits; becomes m_out during precharge
//   precharge  high for the single precharge cycle
//   out_valid  result valid
//   out_ready  downstream accepts the result
//   out_m      masked result
//   m_out      output mask belonging to out_m
// ----------------------------------------------------------------------------
module lmdpl_nand_vec #(
    parameter int WIDTH       = 8,
    parameter int EVAL_CYCLES = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in0_m,
    input  logic [WIDTH-1:0] in1_m,
    input  logic [WIDTH-1:0] m_in0,
    input  logic [WIDTH-1:0] m_in1,
    input  logic [WIDTH-1:0] rnd,
    output logic             precharge,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_m,
    output logic [WIDTH-1:0] m_out
);

    // A one-bit counter is kept even for EVAL_CYCLES == 1 so the vector is never empty.
    localparam int CNT_W = (EVAL_CYCLES > 1) ? $clog2(EVAL_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(EVAL_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_PRECHARGE = 2'd1,
        ST_EVAL      = 2'd2,
        ST_DONE      = 2'd3
    } state_t;

    // Four table entries for one slice, indexed by {a, b}:
    //   t[{a,b}] = ~((a ^ m0) & (b ^ m1)) ^ mo
    // Entry order is {a,b} = 00, 01, 10, 11.
    function automatic logic [3:0] build_slice(input logic m0, input logic m1, input logic mo);
        logic [3:0] t;
        t[0] = ~((1'b0 ^ m0) & (1'b0 ^ m1)) ^ mo;
        t[1] = ~((1'b0 ^ m0) & (1'b1 ^ m1)) ^ mo;
        t[2] = ~((1'b1 ^ m0) & (1'b0 ^ m1)) ^ mo;
        t[3] = ~((1'b1 ^ m0) & (1'b1 ^ m1)) ^ mo;
        return t;
    endfunction

    // Select one table entry using masked operand bits only.
    function automatic logic lookup_slice(input logic [3:0] t, input logic a_m, input logic b_m);
        return t[{a_m, b_m}];
    endfunction

    state_t                 state_r;
    state_t                 state_next_s;
    logic [CNT_W-1:0]       cnt_r;
    logic [WIDTH-1:0]       in0_m_r;
    logic [WIDTH-1:0]       in1_m_r;
    logic [WIDTH-1:0]       m_in0_r;
    logic [WIDTH-1:0]       m_in1_r;
    logic [4*WIDTH-1:0]     tbl_r;
    logic [4*WIDTH-1:0]     tbl_new_s;
    logic [WIDTH-1:0]       eval_res_s;
    logic [WIDTH-1:0]       out_m_r;
    logic [WIDTH-1:0]       m_out_r;
    logic                   in_ready_r;
    logic                   precharge_r;
    logic                   out_valid_r;
    logic                   in_ready_d_s;
    logic                   precharge_d_s;
    logic                   out_valid_d_s;
    logic                   accept_s;
    logic                   release_s;
    logic                   eval_last_s;

    // Handshake and phase events, decoded from registered state only.
    always_comb begin
        accept_s    = (state_r == ST_IDLE) && in_valid;
        release_s   = (state_r == ST_DONE) && out_ready;
        eval_last_s = (state_r == ST_EVAL) && (cnt_r == CNT_ZERO);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    state_next_s = ST_PRECHARGE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_PRECHARGE: begin
                state_next_s = ST_EVAL;
            end
            ST_EVAL: begin
                if (cnt_r == CNT_ZERO) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_EVAL;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_DONE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Status decodes of the next state.
    // They are registered below, so each status output is a pure decode of state_r.
    always_comb begin
        in_ready_d_s  = 1'b0;
        precharge_d_s = 1'b0;
        out_valid_d_s = 1'b0;
        case (state_next_s)
            ST_IDLE:      in_ready_d_s  = 1'b1;
            ST_PRECHARGE: precharge_d_s = 1'b1;
            ST_EVAL:      out_valid_d_s = 1'b0;
            ST_DONE:      out_valid_d_s = 1'b1;
            default:      in_ready_d_s  = 1'b0;
        endcase
    end

    // Status output registers.
    // in_ready comes out of reset high because the reset state is IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_r  <= 1'b1;
            precharge_r <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            in_ready_r  <= in_ready_d_s;
            precharge_r <= precharge_d_s;
            out_valid_r <= out_valid_d_s;
        end
    end

    // Evaluate-phase counter.
    // It is loaded during precharge and counts down to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= CNT_ZERO;
        end else if (state_r == ST_PRECHARGE) begin
            cnt_r <= CNT_LOAD;
        end else if ((state_r == ST_EVAL) && (cnt_r != CNT_ZERO)) begin
            cnt_r <= cnt_r - CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Operand capture.
    // Operands are captured on accept and wiped when the result leaves.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in0_m_r <= {WIDTH{1'b0}};
            in1_m_r <= {WIDTH{1'b0}};
            m_in0_r <= {WIDTH{1'b0}};
            m_in1_r <= {WIDTH{1'b0}};
        end else if (accept_s) begin
            in0_m_r <= in0_m;
            in1_m_r <= in1_m;
            m_in0_r <= m_in0;
            m_in1_r <= m_in1;
        end else if (release_s) begin
            in0_m_r <= {WIDTH{1'b0}};
            in1_m_r <= {WIDTH{1'b0}};
            m_in0_r <= {WIDTH{1'b0}};
            m_in1_r <= {WIDTH{1'b0}};
        end else begin
            in0_m_r <= in0_m_r;
            in1_m_r <= in1_m_r;
            m_in0_r <= m_in0_r;
            m_in1_r <= m_in1_r;
        end
    end

    // Per-slice table construction and masked lookup.
    // The slices are independent, with no cross-bit terms.
    always_comb begin
        tbl_new_s  = {(4*WIDTH){1'b0}};
        eval_res_s = {WIDTH{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            tbl_new_s[4*i +: 4] = build_slice(m_in0_r[i], m_in1_r[i], rnd[i]);
            eval_res_s[i]       = lookup_slice(tbl_r[4*i +: 4], in0_m_r[i], in1_m_r[i]);
        end
    end

    // Output mask and table registers.
    // rnd is sampled only in precharge, and m_out then holds until the next precharge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_out_r <= {WIDTH{1'b0}};
            tbl_r   <= {(4*WIDTH){1'b0}};
        end else if (state_r == ST_PRECHARGE) begin
            m_out_r <= rnd;
            tbl_r   <= tbl_new_s;
        end else if (release_s) begin
            m_out_r <= m_out_r;
            tbl_r   <= {(4*WIDTH){1'b0}};
        end else begin
            m_out_r <= m_out_r;
            tbl_r   <= tbl_r;
        end
    end

    // Masked result register.
    // It is cleared on accept so it reads zero through precharge.
    // It is loaded on the last evaluate cycle and wiped when the result is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_m_r <= {WIDTH{1'b0}};
        end else if (accept_s || release_s) begin
            out_m_r <= {WIDTH{1'b0}};
        end else if (eval_last_s) begin
            out_m_r <= eval_res_s;
        end else begin
            out_m_r <= out_m_r;
        end
    end

    assign in_ready  = in_ready_r;
    assign precharge = precharge_r;
    assign out_valid = out_valid_r;
    assign out_m     = out_m_r;
    assign m_out     = m_out_r;

    lmdpl_nand_vec_chk #(.WIDTH(WIDTH)) u_chk (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_ready  (in_ready_r),
        .precharge (precharge_r),
        .out_valid (out_valid_r),
        .out_ready (out_ready),
        .out_m     (out_m_r),
        .m_out     (m_out_r)
    );

endmodule

// ----------------------------------------------------------------------------
// lmdpl_nand_vec_chk
//
// Protocol properties of the NAND stage outputs. This module has no outputs.
//
// Ports:
//   all inputs; they mirror the stage's status and result outputs
// ----------------------------------------------------------------------------
module lmdpl_nand_vec_chk #(
    parameter int WIDTH = 8
) (
    input logic             clk,
    input logic             rst_n,
    input logic             in_ready,
    input logic             precharge,
    input logic             out_valid,
    input logic             out_ready,
    input logic [WIDTH-1:0] out_m,
    input logic [WIDTH-1:0] m_out
);

    // At most one phase status is active at a time.
    a_one_phase: assert property (@(posedge clk) disable iff (!rst_n)
        !((in_ready && precharge) || (in_ready && out_valid) || (precharge && out_valid)));

    // Precharge lasts exactly one cycle.
    a_pre_single: assert property (@(posedge clk) disable iff (!rst_n)
        precharge |=> !precharge);

    // Output is zero while precharging.
    a_pre_zero: assert property (@(posedge clk) disable iff (!rst_n)
        precharge |-> (out_m == {WIDTH{1'b0}}));

    // A stalled result holds its value and its mask.
    a_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (out_valid && !out_ready) |=> (out_valid && $stable(out_m) && $stable(m_out)));

endmodule

// File: tb/tb_lmdpl_nand_vec.sv
// ----------------------------------------------------------------------------
// tb_lmdpl_nand_vec
//
// Directed self-checking bench for lmdpl_nand_vec. It uses three instances:
//   WIDTH=8  / EVAL_CYCLES=3
//   WIDTH=1  / EVAL_CYCLES=1
//   WIDTH=32 / EVAL_CYCLES=5
// All instances share the operand buses. Each instance has its own
// in_valid and out_ready.
// ----------------------------------------------------------------------------
module tb_lmdpl_nand_vec;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] s_in0_m, s_in1_m, s_m_in0, s_m_in1, s_rnd;
    logic [2:0]  s_in_valid, s_out_ready;

    logic        w8_rdy, w8_pre, w8_ov;
    logic [7:0]  w8_om, w8_mo;
    logic        w1_rdy, w1_pre, w1_ov;
    logic [0:0]  w1_om, w1_mo;
    logic        w32_rdy, w32_pre, w32_ov;
    logic [31:0] w32_om, w32_mo;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    lmdpl_nand_vec #(.WIDTH(8), .EVAL_CYCLES(3)) u_w8 (
        .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid[0]), .in_ready(w8_rdy),
        .in0_m(s_in0_m[7:0]), .in1_m(s_in1_m[7:0]), .m_in0(s_m_in0[7:0]), .m_in1(s_m_in1[7:0]),
        .rnd(s_rnd[7:0]), .precharge(w8_pre), .out_valid(w8_ov), .out_ready(s_out_ready[0]),
        .out_m(w8_om), .m_out(w8_mo));

    lmdpl_nand_vec #(.WIDTH(1), .EVAL_CYCLES(1)) u_w1 (
        .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid[1]), .in_ready(w1_rdy),
        .in0_m(s_in0_m[0:0]), .in1_m(s_in1_m[0:0]), .m_in0(s_m_in0[0:0]), .m_in1(s_m_in1[0:0]),
        .rnd(s_rnd[0:0]), .precharge(w1_pre), .out_valid(w1_ov), .out_ready(s_out_ready[1]),
        .out_m(w1_om), .m_out(w1_mo));

    lmdpl_nand_vec #(.WIDTH(32), .EVAL_CYCLES(5)) u_w32 (
        .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid[2]), .in_ready(w32_rdy),
        .in0_m(s_in0_m), .in1_m(s_in1_m), .m_in0(s_m_in0), .m_in1(s_m_in1),
        .rnd(s_rnd), .precharge(w32_pre), .out_valid(w32_ov), .out_ready(s_out_ready[2]),
        .out_m(w32_om), .m_out(w32_mo));

    // Back-to-back vectors with hand-computed NAND results.
    logic [7:0] b2b_a   [8] = '{8'h33, 8'hFF, 8'h00, 8'hF0, 8'hAA, 8'hC3, 8'h0F, 8'h96};
    logic [7:0] b2b_b   [8] = '{8'h55, 8'hFF, 8'h00, 8'h0F, 8'hAA, 8'h81, 8'h3C, 8'hF0};
    logic [7:0] b2b_exp [8] = '{8'hEE, 8'h00, 8'hFF, 8'hFF, 8'h55, 8'h7E, 8'hF3, 8'h6F};
    logic [7:0] b2b_r   [8] = '{8'h5A, 8'hC3, 8'h01, 8'hFE, 8'h77, 8'h88, 8'h3D, 8'hB4};
    logic [7:0] b2b_m   [8] = '{8'h1F, 8'hE2, 8'h6B, 8'h90, 8'h45, 8'hDC, 8'h07, 8'hA9};

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic get_out(input int sel, output logic rdy, output logic pre, output logic ov,
                           output logic [31:0] om, output logic [31:0] mo);
        case (sel)
            0: begin rdy = w8_rdy; pre = w8_pre; ov = w8_ov; om = {24'h0, w8_om}; mo = {24'h0, w8_mo}; end
            1: begin rdy = w1_rdy; pre = w1_pre; ov = w1_ov; om = {31'h0, w1_om}; mo = {31'h0, w1_mo}; end
            default: begin rdy = w32_rdy; pre = w32_pre; ov = w32_ov; om = w32_om; mo = w32_mo; end
        endcase
    endtask

    // One operation on instance sel. Call at a negedge.
    // hold: cycles of out_ready=0 with in_valid=1 after the result appears.
    task automatic run_op(input int sel, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] m0, input logic [31:0] m1, input logic [31:0] r,
                          input logic [31:0] expv, input int lat_exp, input int hold, input string tag);
        logic rdy, pre, ov;
        logic [31:0] om, mo, om_h, mo_h;
        int lat, pc, t;
        bit seen;
        get_out(sel, rdy, pre, ov, om, mo);
        t = 0;
        while (!rdy && t < 20) begin
            @(negedge clk);
            get_out(sel, rdy, pre, ov, om, mo);
            t++;
        end
        if (!rdy) check_eq($sformatf("%s.ready_timeout", tag), {31'h0, rdy}, 32'd1);
        s_in0_m = a ^ m0; s_in1_m = b ^ m1; s_m_in0 = m0; s_m_in1 = m1; s_rnd = r;
        s_in_valid[sel] = 1'b1; s_out_ready[sel] = 1'b0;
        @(posedge clk); #1;
        // Operands are don't-care after the accepting edge: scramble them.
        s_in_valid[sel] = 1'b0;
        s_in0_m = ~s_in0_m; s_in1_m = ~s_in1_m; s_m_in0 = ~s_m_in0; s_m_in1 = ~s_m_in1;
        lat = 0; pc = 0; seen = 1'b0;
        while (!seen && lat <= 20) begin
            @(negedge clk);
            get_out(sel, rdy, pre, ov, om, mo);
            if (pre) begin
                pc++;
                check_eq($sformatf("%s.pre_out_m", tag), om, 32'h0);
            end
            if (ov) begin
                seen = 1'b1;
            end else begin
                @(posedge clk); #1;
                lat++;
                if (lat == 1) s_rnd = ~r;  // rnd was sampled at this edge; change it
            end
        end
        check_eq($sformatf("%s.latency", tag), lat, lat_exp);
        check_eq($sformatf("%s.pre_cycles", tag), pc, 32'd1);
        check_eq($sformatf("%s.unmasked", tag), om ^ mo, expv);
        check_eq($sformatf("%s.m_out", tag), mo, r);
        om_h = om; mo_h = mo;
        if (hold > 0) begin
            s_in_valid[sel] = 1'b1;
            for (int h = 0; h < hold; h++) begin
                s_in0_m = $urandom; s_in1_m = $urandom; s_rnd = $urandom;
                @(posedge clk); #1;
                @(negedge clk);
                get_out(sel, rdy, pre, ov, om, mo);
                check_eq($sformatf("%s.bp_out_m", tag), om, om_h);
                check_eq($sformatf("%s.bp_m_out", tag), mo, mo_h);
                check_eq($sformatf("%s.bp_in_ready", tag), {31'h0, rdy}, 32'd0);
                check_eq($sformatf("%s.bp_out_valid", tag), {31'h0, ov}, 32'd1);
            end
        end
        s_in_valid[sel] = 1'b0; s_out_ready[sel] = 1'b1;
        @(posedge clk); #1;
        s_out_ready[sel] = 1'b0;
        @(negedge clk);
        get_out(sel, rdy, pre, ov, om, mo);
        check_eq($sformatf("%s.rel_in_ready", tag), {31'h0, rdy}, 32'd1);
        check_eq($sformatf("%s.rel_out_valid", tag), {31'h0, ov}, 32'd0);
    endtask

    initial begin
        logic rdy, pre, ov;
        logic [31:0] om, mo;
        int nacc, nout, last;
        bit seen;

        rst_n = 1'b0;
        s_in0_m = 32'h0; s_in1_m = 32'h0; s_m_in0 = 32'h0; s_m_in1 = 32'h0; s_rnd = 32'h0;
        s_in_valid = 3'b000; s_out_ready = 3'b000;
        repeat (2) @(negedge clk);
        get_out(0, rdy, pre, ov, om, mo);
        check_eq("rst.out_valid", {31'h0, ov}, 32'd0);
        check_eq("rst.precharge", {31'h0, pre}, 32'd0);
        check_eq("rst.out_m", om, 32'h0);
        check_eq("rst.m_out", mo, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        get_out(0, rdy, pre, ov, om, mo);
        check_eq("rst.in_ready", {31'h0, rdy}, 32'd1);

        // Truth table: in0=0011_0011, in1=0101_0101 -> NAND 1110_1110
        run_op(0, 32'h33, 32'h55, 32'h00, 32'h00, 32'h00, 32'hEE, 4, 0, "tt0");
        run_op(0, 32'h33, 32'h55, 32'hFF, 32'hFF, 32'hFF, 32'hEE, 4, 0, "tt1");
        run_op(0, 32'h33, 32'h55, 32'hA5, 32'h3C, 32'h96, 32'hEE, 4, 0, "tt2");
        run_op(0, 32'h33, 32'h55, 32'h12, 32'h34, 32'h56, 32'hEE, 4, 0, "tt3");

        // Mask independence
        for (int k = 0; k < 100; k++) begin
            run_op(0, 32'h33, 32'h55, {24'h0, 8'($urandom_range(0, 255))},
                   {24'h0, 8'($urandom_range(0, 255))}, {24'h0, 8'($urandom_range(0, 255))},
                   32'hEE, 4, 0, "mi");
        end

        // Backpressure for 10 cycles
        run_op(0, 32'h33, 32'h55, 32'h6C, 32'h39, 32'hC7, 32'hEE, 4, 10, "bp");

        // Reset one cycle into EVAL
        s_in0_m = 32'h33 ^ 32'h0F; s_in1_m = 32'h55 ^ 32'hF0;
        s_m_in0 = 32'h0F; s_m_in1 = 32'hF0; s_rnd = 32'h5A;
        s_in_valid[0] = 1'b1;
        @(posedge clk); #1;
        s_in_valid[0] = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2 rst_n = 1'b0;
        #1;
        get_out(0, rdy, pre, ov, om, mo);
        check_eq("mid.out_m", om, 32'h0);
        check_eq("mid.m_out", mo, 32'h0);
        check_eq("mid.out_valid", {31'h0, ov}, 32'd0);
        check_eq("mid.precharge", {31'h0, pre}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        get_out(0, rdy, pre, ov, om, mo);
        check_eq("mid.in_ready", {31'h0, rdy}, 32'd1);
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (w8_ov) seen = 1'b1;
        end
        check_eq("mid.discarded", {31'h0, seen}, 32'd0);
        run_op(0, 32'hF0, 32'h0F, 32'h21, 32'h43, 32'h65, 32'hFF, 4, 0, "mid_rec");

        // Parametrisation
        run_op(1, 32'h1, 32'h1, 32'h1, 32'h0, 32'h1, 32'h0, 2, 0, "w1_11");
        run_op(1, 32'h1, 32'h0, 32'h0, 32'h1, 32'h0, 32'h1, 2, 0, "w1_10");
        run_op(1, 32'h0, 32'h1, 32'h1, 32'h1, 32'h1, 32'h1, 2, 0, "w1_01");
        run_op(2, 32'hFFFF_0000, 32'hFF00_FF00, 32'h9E37_79B9, 32'h7F4A_7C15, 32'hDEAD_BEEF,
               32'h00FF_FFFF, 6, 0, "w32_a");
        run_op(2, 32'h1234_5678, 32'h0F0F_0F0F, 32'hC0FF_EE00, 32'h0BAD_F00D, 32'h8000_0001,
               32'hFDFB_F9F7, 6, 0, "w32_b");

        // Back-to-back: in_valid and out_ready held high
        nacc = 0; nout = 0; last = 0;
        s_out_ready[0] = 1'b1;
        for (int cyc = 0; cyc < 200 && nout < 8; cyc++) begin
            @(negedge clk);
            get_out(0, rdy, pre, ov, om, mo);
            if (ov) begin
                check_eq($sformatf("b2b%0d.unmasked", nout), om ^ mo, {24'h0, b2b_exp[nout]});
                check_eq($sformatf("b2b%0d.m_out", nout), mo, {24'h0, b2b_r[nout]});
                if (nout > 0) check_eq($sformatf("b2b%0d.period", nout), cyc - last, 32'd6);
                last = cyc;
                nout++;
            end
            if (rdy) begin
                if (nacc < 8) begin
                    s_in0_m = {24'h0, b2b_a[nacc] ^ b2b_m[nacc]};
                    s_in1_m = {24'h0, b2b_b[nacc] ^ ~b2b_m[nacc]};
                    s_m_in0 = {24'h0, b2b_m[nacc]};
                    s_m_in1 = {24'h0, ~b2b_m[nacc]};
                    s_rnd   = {24'h0, b2b_r[nacc]};
                    s_in_valid[0] = 1'b1;
                    nacc++;
                end else begin
                    s_in_valid[0] = 1'b0;
                end
            end
        end
        s_in_valid[0] = 1'b0;
        check_eq("b2b.count", nout, 32'd8);
        @(posedge clk); #1;
        s_out_ready[0] = 1'b0;
        @(negedge clk);
        check_eq("b2b.final_ready", {31'h0, w8_rdy}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
